// File: rtl/adder_tree_stream.sv
// Streaming pipelined adder tree: masked, optionally signed operands, one beat per clock.
// Define ADDER_TREE_STREAM_ACC_EN to add a frame accumulator behind the tree output.
module adder_tree_stream #(
  parameter int INPUTS_NUM  = 125,
  parameter int IDATA_WIDTH = 16,
  parameter bit SIGNED      = 1'b0,
  parameter int REG_EVERY   = 1,
  parameter int ACC_WIDTH   = 8,
  localparam int STAGES_NUM = $clog2(INPUTS_NUM),
`ifdef ADDER_TREE_STREAM_ACC_EN
  localparam int ODATA_WIDTH = IDATA_WIDTH + STAGES_NUM + ACC_WIDTH
`else
  localparam int ODATA_WIDTH = IDATA_WIDTH + STAGES_NUM
`endif
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   ivalid,
  input  logic [INPUTS_NUM-1:0]                  imask,
  input  logic [INPUTS_NUM-1:0][IDATA_WIDTH-1:0] idata,
  input  logic                                   ilast,
  output logic                                   ovalid,
  output logic [ODATA_WIDTH-1:0]                 odata
);

  localparam int LEAVES = 1 << STAGES_NUM;
  localparam int TREE_W = IDATA_WIDTH + STAGES_NUM;

  genvar gi, gj;
  generate
    for (gi = 0; gi <= STAGES_NUM; gi++) begin : g_stage
      localparam int W = IDATA_WIDTH + gi;
      localparam int N = LEAVES >> gi;
      logic [W-1:0] node [N];
      logic         vld;
      logic         last;

      if (gi == 0) begin : g_leaf
        for (gj = 0; gj < N; gj++) begin : g_op
          if (gj < INPUTS_NUM) begin : g_used
            assign node[gj] = imask[gj] ? idata[gj] : '0;
          end else begin : g_pad
            assign node[gj] = '0;
          end
        end
        assign vld  = ivalid;
        assign last = ilast;
      end else begin : g_add
        localparam bit HAS_RANK = ((gi % REG_EVERY) == 0) || (gi == STAGES_NUM);
        logic [W-1:0] sum [N];

        // Each stage grows by one bit, so the pairwise add never overflows.
        for (gj = 0; gj < N; gj++) begin : g_pair
          logic [W-2:0] a_op;
          logic [W-2:0] b_op;
          assign a_op    = g_stage[gi-1].node[2*gj];
          assign b_op    = g_stage[gi-1].node[2*gj+1];
          assign sum[gj] = {SIGNED & a_op[W-2], a_op} + {SIGNED & b_op[W-2], b_op};
        end

        if (HAS_RANK) begin : g_rank
          logic [W-1:0] data_q [N];
          logic [W-1:0] data_d [N];
          logic         vld_q;
          logic         vld_d;
          logic         last_q;
          logic         last_d;

          // Data only moves with a valid beat so idle ranks keep toggling to a minimum.
          always_comb begin
            data_d = data_q;
            last_d = last_q;
            vld_d  = g_stage[gi-1].vld;
            if (g_stage[gi-1].vld) begin
              data_d = sum;
              last_d = g_stage[gi-1].last;
            end
          end

          always_ff @(posedge clk) begin
            if (!nrst) begin
              vld_q  <= 1'b0;
              last_q <= 1'b0;
              for (int k = 0; k < N; k++) begin
                data_q[k] <= '0;
              end
            end else begin
              vld_q  <= vld_d;
              last_q <= last_d;
              data_q <= data_d;
            end
          end

          assign node = data_q;
          assign vld  = vld_q;
          assign last = last_q;
        end else begin : g_comb
          assign node = sum;
          assign vld  = g_stage[gi-1].vld;
          assign last = g_stage[gi-1].last;
        end
      end
    end
  endgenerate

  logic [TREE_W-1:0] tree_sum;
  logic              tree_vld;
  logic              tree_last;

  assign tree_sum  = g_stage[STAGES_NUM].node[0];
  assign tree_vld  = g_stage[STAGES_NUM].vld;
  assign tree_last = g_stage[STAGES_NUM].last;

`ifdef ADDER_TREE_STREAM_ACC_EN
  logic [ODATA_WIDTH-1:0] acc_q;
  logic [ODATA_WIDTH-1:0] acc_d;
  logic [ODATA_WIDTH-1:0] odata_q;
  logic [ODATA_WIDTH-1:0] odata_d;
  logic                   ovalid_q;
  logic                   ovalid_d;
  logic [ODATA_WIDTH-1:0] tree_ext;
  logic [ODATA_WIDTH-1:0] frame_sum;

  assign tree_ext  = {{ACC_WIDTH{SIGNED & tree_sum[TREE_W-1]}}, tree_sum};
  assign frame_sum = acc_q + tree_ext;

  // A last result emits the frame total and reseeds the accumulator at zero.
  always_comb begin
    acc_d    = acc_q;
    odata_d  = odata_q;
    ovalid_d = 1'b0;
    if (tree_vld) begin
      if (tree_last) begin
        odata_d  = frame_sum;
        ovalid_d = 1'b1;
        acc_d    = '0;
      end else begin
        acc_d = frame_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      acc_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign ovalid = ovalid_q;
  assign odata  = odata_q;
`else
  localparam int unused_acc_width = ACC_WIDTH;
  logic unused_last;

  assign unused_last = tree_last;
  assign ovalid      = tree_vld;
  assign odata       = tree_sum;
`endif

endmodule

// File: tb/tb_adder_tree_stream.sv
// Directed self-checking bench for adder_tree_stream across several parameter sets.
`timescale 1ns/1ps
module tb_adder_tree_stream;

`ifdef ADDER_TREE_STREAM_ACC_EN
  localparam int ACC_EXTRA = 1;
  localparam int AW        = 8;
  localparam int B_AW      = 2;
`else
  localparam int ACC_EXTRA = 0;
  localparam int AW        = 0;
  localparam int B_AW      = 0;
`endif
  localparam int BIG_OW  = 23 + AW;
  localparam int BIG_LAT = 7 + ACC_EXTRA;
  localparam int RE3_LAT = 3 + ACC_EXTRA;
  localparam int SGN_OW  = 11 + AW;
  localparam int SGN_LAT = 3 + ACC_EXTRA;
  localparam int B_OW    = 10 + B_AW;
  localparam int B_LAT   = 2 + ACC_EXTRA;

  logic clk;
  logic nrst;

  logic                  big_ivalid;
  logic [124:0]          big_imask;
  logic [124:0][15:0]    big_idata;
  logic                  big_ilast;
  logic                  big_ovalid;
  logic [BIG_OW-1:0]     big_odata;
  logic                  re3_ovalid;
  logic [BIG_OW-1:0]     re3_odata;

  logic                  sgn_ivalid;
  logic [4:0]            sgn_imask;
  logic [4:0][7:0]       sgn_idata;
  logic                  sgn_ilast;
  logic                  sgn_ovalid;
  logic [SGN_OW-1:0]     sgn_odata;

  logic                  b_ivalid;
  logic [3:0]            b_imask;
  logic [3:0][7:0]       b_idata;
  logic                  b_ilast;
  logic                  b_ovalid;
  logic [B_OW-1:0]       b_odata;

  int errors = 0;
  int checks = 0;

  adder_tree_stream #(.INPUTS_NUM(125), .IDATA_WIDTH(16), .SIGNED(1'b0), .REG_EVERY(1)) u_big (
    .clk(clk), .nrst(nrst), .ivalid(big_ivalid), .imask(big_imask), .idata(big_idata),
    .ilast(big_ilast), .ovalid(big_ovalid), .odata(big_odata));

  adder_tree_stream #(.INPUTS_NUM(125), .IDATA_WIDTH(16), .SIGNED(1'b0), .REG_EVERY(3)) u_re3 (
    .clk(clk), .nrst(nrst), .ivalid(big_ivalid), .imask(big_imask), .idata(big_idata),
    .ilast(big_ilast), .ovalid(re3_ovalid), .odata(re3_odata));

  adder_tree_stream #(.INPUTS_NUM(5), .IDATA_WIDTH(8), .SIGNED(1'b1), .REG_EVERY(1)) u_sgn (
    .clk(clk), .nrst(nrst), .ivalid(sgn_ivalid), .imask(sgn_imask), .idata(sgn_idata),
    .ilast(sgn_ilast), .ovalid(sgn_ovalid), .odata(sgn_odata));

  adder_tree_stream #(.INPUTS_NUM(4), .IDATA_WIDTH(8), .SIGNED(1'b0), .REG_EVERY(1),
                      .ACC_WIDTH(2)) u_b (
    .clk(clk), .nrst(nrst), .ivalid(b_ivalid), .imask(b_imask), .idata(b_idata),
    .ilast(b_ilast), .ovalid(b_ovalid), .odata(b_odata));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    tick();
    tick();
    checks++;
    if (big_ovalid !== 1'b0 || big_odata !== '0) begin
      errors++;
      $display("FAIL reset_big ovalid=%0b odata=%0d required 0/0", big_ovalid, big_odata);
    end
    checks++;
    if (re3_ovalid !== 1'b0 || re3_odata !== '0) begin
      errors++;
      $display("FAIL reset_re3 ovalid=%0b odata=%0d required 0/0", re3_ovalid, re3_odata);
    end
    checks++;
    if (sgn_ovalid !== 1'b0 || sgn_odata !== '0) begin
      errors++;
      $display("FAIL reset_sgn ovalid=%0b odata=%0d required 0/0", sgn_ovalid, sgn_odata);
    end
    checks++;
    if (b_ovalid !== 1'b0 || b_odata !== '0) begin
      errors++;
      $display("FAIL reset_b ovalid=%0b odata=%0d required 0/0", b_ovalid, b_odata);
    end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_all_ones();
    big_imask = '1;
    for (int i = 0; i < 125; i++) big_idata[i] = 16'hFFFF;
    big_ivalid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      big_ivalid = 1'b0;
      checks++;
      if (big_ovalid !== (c == BIG_LAT)) begin
        errors++;
        $display("FAIL all_ones_big_valid cycle=%0d ovalid=%0b required %0b", c, big_ovalid, c == BIG_LAT);
      end
      checks++;
      if (re3_ovalid !== (c == RE3_LAT)) begin
        errors++;
        $display("FAIL all_ones_re3_valid cycle=%0d ovalid=%0b required %0b", c, re3_ovalid, c == RE3_LAT);
      end
      if (c >= BIG_LAT) begin
        checks++;
        if (big_odata !== 8191875) begin
          errors++;
          $display("FAIL all_ones_big_data cycle=%0d odata=%0d required 8191875", c, big_odata);
        end else if (c == BIG_LAT) begin
          $display("all_ones big beat: odata=%0d", big_odata);
        end
      end
      if (c >= RE3_LAT) begin
        checks++;
        if (re3_odata !== 8191875) begin
          errors++;
          $display("FAIL all_ones_re3_data cycle=%0d odata=%0d required 8191875", c, re3_odata);
        end else if (c == RE3_LAT) begin
          $display("all_ones re3 beat: odata=%0d", re3_odata);
        end
      end
    end
  endtask

  task automatic test_signed();
    int exp_s [3];
    int k;
    exp_s = '{-129, -128, 127};
    sgn_idata  = {8'hFF, 8'h01, 8'h7F, 8'h80, 8'h80};
    sgn_imask  = 5'b11111;
    sgn_ivalid = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 1) sgn_imask = 5'b01111;
      else if (c == 2) sgn_imask = 5'b00100;
      else sgn_ivalid = 1'b0;
      k = c - SGN_LAT + 1;
      checks++;
      if (sgn_ovalid !== (k >= 1 && k <= 3)) begin
        errors++;
        $display("FAIL signed_valid cycle=%0d ovalid=%0b required %0b", c, sgn_ovalid, k >= 1 && k <= 3);
      end
      if (k >= 1 && k <= 3) begin
        checks++;
        if ($signed(sgn_odata) !== exp_s[k-1]) begin
          errors++;
          $display("FAIL signed_data beat=%0d odata=%0d required %0d", k, $signed(sgn_odata), exp_s[k-1]);
        end else begin
          $display("signed beat %0d: odata=%0d", k, $signed(sgn_odata));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int vals [10];
    int hold;
    int j;
    vals = '{1, 2, 3, 0, 0, 4, 0, 0, 0, 0};
    hold = 0;
    b_imask = 4'hF;
    for (int c = 0; c < 10; c++) begin
      b_ivalid = (vals[c] != 0);
      for (int i = 0; i < 4; i++) b_idata[i] = 8'(vals[c]);
      tick();
      j = c + 1 - B_LAT;
      checks++;
      if (j >= 0 && vals[j] != 0) begin
        hold = 4 * vals[j];
        if (b_ovalid !== 1'b1 || b_odata !== hold) begin
          errors++;
          $display("FAIL b2b_beat cycle=%0d ovalid=%0b odata=%0d required 1/%0d", c, b_ovalid, b_odata, hold);
        end else begin
          $display("b2b beat: odata=%0d", b_odata);
        end
      end else if (b_ovalid !== 1'b0 || b_odata !== hold) begin
        errors++;
        $display("FAIL b2b_idle cycle=%0d ovalid=%0b odata=%0d required 0/%0d", c, b_ovalid, b_odata, hold);
      end
    end
    b_ivalid = 1'b0;
  endtask

  task automatic test_mask_unsigned();
    int exp_u [3];
    int j;
    exp_u = '{1020, 510, 512};
    for (int c = 0; c < 6; c++) begin
      b_ivalid = (c < 3);
      b_imask  = (c == 1) ? 4'b0101 : 4'b1111;
      for (int i = 0; i < 4; i++) b_idata[i] = (c == 2) ? 8'h80 : 8'hFF;
      tick();
      j = c + 1 - B_LAT;
      checks++;
      if (j >= 0 && j < 3) begin
        if (b_ovalid !== 1'b1 || b_odata !== exp_u[j]) begin
          errors++;
          $display("FAIL mask_unsigned beat=%0d ovalid=%0b odata=%0d required 1/%0d", j, b_ovalid, b_odata, exp_u[j]);
        end else begin
          $display("mask_unsigned beat %0d: odata=%0d", j, b_odata);
        end
      end else if (b_ovalid !== 1'b0) begin
        errors++;
        $display("FAIL mask_unsigned_idle cycle=%0d ovalid=%0b required 0", c, b_ovalid);
      end
    end
    b_ivalid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    big_imask = '1;
    for (int i = 0; i < 125; i++) big_idata[i] = 16'd1;
    big_ivalid = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    big_ivalid = 1'b0;
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (big_ovalid !== 1'b0 || big_odata !== '0) begin
        errors++;
        $display("FAIL flush cycle=%0d ovalid=%0b odata=%0d required 0/0", c, big_ovalid, big_odata);
      end
    end
    for (int i = 0; i < 125; i++) big_idata[i] = 16'd2;
    big_ivalid = 1'b1;
    for (int c = 1; c <= BIG_LAT + 1; c++) begin
      tick();
      big_ivalid = 1'b0;
      checks++;
      if (big_ovalid !== (c == BIG_LAT)) begin
        errors++;
        $display("FAIL post_reset_valid cycle=%0d ovalid=%0b required %0b", c, big_ovalid, c == BIG_LAT);
      end
      if (c == BIG_LAT) begin
        checks++;
        if (big_odata !== 250) begin
          errors++;
          $display("FAIL post_reset_data odata=%0d required 250", big_odata);
        end else begin
          $display("post_reset beat: odata=%0d", big_odata);
        end
      end
    end
  endtask

`ifdef ADDER_TREE_STREAM_ACC_EN
  task automatic test_accumulate();
    int op0 [10];
    int op1 [10];
    int op2 [10];
    int op3 [10];
    bit lst [10];
    bit vld [10];
    int exp_o [10];
    int j;
    op0   = '{1, 5, 0, 7, 0, 255, 255, 255, 255, 255};
    op1   = '{2, 5, 10, 0, 0, 255, 255, 255, 255, 255};
    op2   = '{3, 5, 10, 0, 0, 255, 255, 255, 255, 255};
    op3   = '{4, 5, 10, 0, 0, 255, 255, 255, 255, 255};
    lst   = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1};
    vld   = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    exp_o = '{-1, -1, 60, 7, -1, -1, -1, -1, -1, 1004};
    b_imask = 4'hF;
    for (int c = 0; c < 14; c++) begin
      if (c < 10) begin
        b_ivalid   = vld[c];
        b_ilast    = lst[c];
        b_idata[0] = 8'(op0[c]);
        b_idata[1] = 8'(op1[c]);
        b_idata[2] = 8'(op2[c]);
        b_idata[3] = 8'(op3[c]);
      end else begin
        b_ivalid = 1'b0;
      end
      tick();
      j = c + 1 - B_LAT;
      checks++;
      if (j >= 0 && j < 10 && exp_o[j] >= 0) begin
        if (b_ovalid !== 1'b1 || b_odata !== exp_o[j]) begin
          errors++;
          $display("FAIL acc_frame beat=%0d ovalid=%0b odata=%0d required 1/%0d", j, b_ovalid, b_odata, exp_o[j]);
        end else begin
          $display("acc frame end at beat %0d: odata=%0d", j, b_odata);
        end
      end else if (b_ovalid !== 1'b0) begin
        errors++;
        $display("FAIL acc_no_pulse cycle=%0d ovalid=%0b required 0", c, b_ovalid);
      end
    end
    b_ilast = 1'b1;
  endtask
`endif

  initial begin
    nrst       = 1'b0;
    big_ivalid = 1'b0;
    big_imask  = '0;
    big_idata  = '0;
    big_ilast  = 1'b1;
    sgn_ivalid = 1'b0;
    sgn_imask  = '0;
    sgn_idata  = '0;
    sgn_ilast  = 1'b1;
    b_ivalid   = 1'b0;
    b_imask    = '0;
    b_idata    = '0;
    b_ilast    = 1'b1;

    test_reset();
    test_all_ones();
    test_signed();
    test_back_to_back();
    test_mask_unsigned();
    test_reset_midflight();
`ifdef ADDER_TREE_STREAM_ACC_EN
    test_accumulate();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
